// File: rtl/not_arb_pkg.sv
// Shared types and helpers for the not_share_arbiter slice.
// Build option: NOT_ARB_FIXED_PRIO_EN selects fixed priority instead of round-robin.
package not_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    EXEC = 1'b1
  } not_arb_state_t;

  // Requester ID width; a single requester still gets a 1-bit ID.
  function automatic int id_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Reset value of the round-robin pointer, so that requester 0 wins first.
  function automatic int last_reset(input int n);
    return n - 1;
  endfunction

endpackage

// File: rtl/not_share_arbiter_c_not.sv
// Shared inverter cell that all requesters take turns using.
module C_NOT (
  input  logic a,
  output logic c
);

  assign c = ~a;

endmodule

// File: rtl/not_share_arbiter.sv
// Shares one C_NOT cell between N_REQ requesters; one operation per two cycles.
// Build option: NOT_ARB_FIXED_PRIO_EN (lowest index wins, no round-robin pointer).
module not_share_arbiter
  import not_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = id_w(N_REQ)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] req_data,
  output logic [N_REQ-1:0] gnt,
  output logic             rsp_valid,
  output logic [ID_W-1:0]  rsp_id,
  output logic             rsp_data,
  output logic [N_REQ-1:0] pending,
  output logic [N_REQ-1:0] ovf,
  output logic             busy
);

  not_arb_state_t   state;
  logic [N_REQ-1:0] opnd;
  logic             gate_a;
  logic             gate_c;
  logic [ID_W-1:0]  cur_id;
  logic [ID_W-1:0]  win;
  logic             grant_now;

  assign grant_now = (state == IDLE) && ena && (|pending);
  assign busy      = (state != IDLE) || (|pending);

`ifdef NOT_ARB_FIXED_PRIO_EN
  always_comb begin
    win = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (pending[i]) win = ID_W'(i);
    end
  end
`else
  logic [ID_W-1:0] last;
  logic            found;
  int              idx;

  // Search begins just after the previous winner and wraps around.
  always_comb begin
    win   = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = (int'(last) + k) % N_REQ;
      if (!found && pending[idx]) begin
        found = 1'b1;
        win   = ID_W'(idx);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last <= ID_W'(last_reset(N_REQ));
    end else if (grant_now) begin
      last <= win;
    end
  end
`endif

  C_NOT u_gate (
    .a(gate_a),
    .c(gate_c)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      gnt       <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= 1'b0;
      rsp_id    <= '0;
      cur_id    <= '0;
      gate_a    <= 1'b0;
      pending   <= '0;
      opnd      <= '0;
      ovf       <= '0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_now) begin
            state  <= EXEC;
            gnt    <= N_REQ'(1) << win;
            gate_a <= opnd[win];
            cur_id <= win;
          end
        end
        EXEC: begin
          rsp_data  <= gate_c;
          rsp_id    <= cur_id;
          rsp_valid <= 1'b1;
          gnt       <= '0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
      // A new request on the granting edge refills the slot instead of overflowing.
      for (int i = 0; i < N_REQ; i++) begin
        if (req[i]) begin
          if (!pending[i] || (grant_now && (win == ID_W'(i)))) begin
            pending[i] <= 1'b1;
            opnd[i]    <= req_data[i];
          end else begin
            ovf[i] <= 1'b1;
          end
        end else if (grant_now && (win == ID_W'(i))) begin
          pending[i] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_not_share_arbiter.sv
// Scoreboard bench for not_share_arbiter: expected responses are queued with the stimulus
// and popped by a monitor whenever rsp_valid fires.
module tb_not_share_arbiter;

  localparam int N_REQ = 4;
  localparam int ID_W  = 2;

  typedef struct {
    logic [ID_W-1:0] id;
    logic            data;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             ena;
  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] req_data;
  logic [N_REQ-1:0] gnt;
  logic             rsp_valid;
  logic [ID_W-1:0]  rsp_id;
  logic             rsp_data;
  logic [N_REQ-1:0] pending;
  logic [N_REQ-1:0] ovf;
  logic             busy;

  exp_t sb[$];
  int   rspCycles[$];
  int   cycleCount = 0;
  int   numChecks  = 0;
  int   numErrors  = 0;
  logic prevValid  = 1'b0;

  not_share_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W)) dut (
    .clk(clk), .rst(rst), .ena(ena), .req(req), .req_data(req_data),
    .gnt(gnt), .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .pending(pending), .ovf(ovf), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycleCount++;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    numChecks++;
    if (observed !== expected) begin
      numErrors++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [N_REQ-1:0] r, input logic [N_REQ-1:0] d);
    req      = r;
    req_data = d;
    stepCycle();
    req      = '0;
    req_data = '0;
  endtask

  task automatic pushExp(input int id, input logic data);
    exp_t e;
    e.id   = ID_W'(id);
    e.data = data;
    sb.push_back(e);
  endtask

  task automatic doReset();
    rst = 1'b1;
    req = '0;
    req_data = '0;
    ena = 1'b1;
    sb.delete();
    stepCycle();
    stepCycle();
    rst = 1'b0;
    rspCycles.delete();
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && sb.size() != 0; i++) stepCycle();
    checkOutput("drain_left", sb.size(), 0);
  endtask

  // Monitor compares each result strobe against the oldest expected entry.
  always @(negedge clk) begin
    if (!rst && rsp_valid) begin
      checkOutput("rsp_back2back", {31'b0, prevValid}, 0);
      checkOutput("rsp_expected", {31'b0, (sb.size() > 0)}, 1);
      if (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        checkOutput("rsp_id", rsp_id, e.id);
        checkOutput("rsp_data", rsp_data, e.data);
      end
      rspCycles.push_back(cycleCount);
    end
    prevValid = rsp_valid && !rst;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected finish before timeout");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst = 1'b1;
    ena = 1'b1;
    req = '0;
    req_data = '0;
    #2;
    checkOutput("rst_gnt", gnt, 0);
    checkOutput("rst_pending", pending, 0);
    checkOutput("rst_ovf", ovf, 0);
    checkOutput("rst_rsp_valid", rsp_valid, 0);
    checkOutput("rst_rsp_id", rsp_id, 0);
    checkOutput("rst_rsp_data", rsp_data, 0);
    checkOutput("rst_busy", busy, 0);
    doReset();

    // Single request: gnt two cycles later, response one cycle after that.
    pushExp(0, 1'b0);
    applyStimulus(4'b0001, 4'b0001);
    checkOutput("single_pending", pending, 4'b0001);
    checkOutput("single_busy", busy, 1);
    stepCycle();
    checkOutput("single_gnt", gnt, 4'b0001);
    stepCycle();
    checkOutput("single_rsp_valid", rsp_valid, 1);
    checkOutput("single_gnt_off", gnt, 0);
    drain();

    // All four at once: responses in index order, two cycles apart.
    doReset();
    pushExp(0, 1'b0); pushExp(1, 1'b1); pushExp(2, 1'b0); pushExp(3, 1'b1);
    applyStimulus(4'b1111, 4'b0101);
    drain();
    stepCycle();
    checkOutput("all_rsp_count", rspCycles.size(), 4);
    for (int i = 0; i + 1 < rspCycles.size(); i++)
      checkOutput("all_rsp_spacing", rspCycles[i+1] - rspCycles[i], 2);

    // Fairness: requester 0 keeps coming back while requester 2 waits.
    doReset();
`ifdef NOT_ARB_FIXED_PRIO_EN
    pushExp(0, 1'b0); pushExp(0, 1'b1); pushExp(2, 1'b1);
`else
    pushExp(0, 1'b0); pushExp(2, 1'b1); pushExp(0, 1'b1); pushExp(2, 1'b0);
`endif
    applyStimulus(4'b0101, 4'b0001);
    applyStimulus(4'b0000, 4'b0000);
    applyStimulus(4'b0001, 4'b0000);
    applyStimulus(4'b0000, 4'b0000);
    applyStimulus(4'b0100, 4'b0100);
    drain();
`ifdef NOT_ARB_FIXED_PRIO_EN
    checkOutput("fair_ovf", ovf, 4'b0100);
`else
    checkOutput("fair_ovf", ovf, 4'b0000);
`endif

    // Overflow: second request while blocked is dropped, first operand kept.
    doReset();
    ena = 1'b0;
    applyStimulus(4'b0010, 4'b0010);
    applyStimulus(4'b0000, 4'b0000);
    applyStimulus(4'b0010, 4'b0000);
    checkOutput("ovf_flag", ovf, 4'b0010);
    checkOutput("ovf_pending", pending, 4'b0010);
    checkOutput("ovf_gnt_blocked", gnt, 0);
    pushExp(1, 1'b0);
    ena = 1'b1;
    drain();
    for (int i = 0; i < 6; i++) stepCycle();
    checkOutput("ovf_sticky", ovf, 4'b0010);
    checkOutput("ovf_idle_busy", busy, 0);

    // Same-edge accept: re-request on the granting edge is kept, not dropped.
    doReset();
    pushExp(3, 1'b0); pushExp(3, 1'b1);
    applyStimulus(4'b1000, 4'b1000);
    applyStimulus(4'b1000, 4'b0000);
    checkOutput("same_gnt", gnt, 4'b1000);
    checkOutput("same_pending", pending, 4'b1000);
    checkOutput("same_ovf", ovf, 0);
    drain();
    checkOutput("same_ovf_end", ovf, 0);

    // Reset during EXEC discards the operation.
    doReset();
    applyStimulus(4'b0101, 4'b0001);
    stepCycle();
    checkOutput("mid_gnt", gnt, 4'b0001);
    rst = 1'b1;
    #1;
    checkOutput("mid_rst_gnt", gnt, 0);
    checkOutput("mid_rst_pending", pending, 0);
    checkOutput("mid_rst_rsp_valid", rsp_valid, 0);
    checkOutput("mid_rst_busy", busy, 0);
    stepCycle();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      stepCycle();
      checkOutput("mid_no_rsp", rsp_valid, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", numChecks, numErrors);
    $finish;
  end

endmodule
